// File: rtl/pe_index_sequencer.sv
// Drives a single-shot priority encoder repeatedly and streams one index per set bit of each request vector.
// Optional WAIT watchdog enabled by defining PE_SEQ_TIMEOUT_EN.
module pe_index_sequencer #(
    parameter int DATA_LEN       = 20,
    parameter int RESULT_LEN     = $clog2(DATA_LEN),
    parameter int CNT_LEN        = $clog2(DATA_LEN + 1),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_LEN-1:0]   in_data,
    output logic [DATA_LEN-1:0]   pe_data_in,
    output logic                  pe_start,
    input  logic                  pe_ready,
    input  logic                  pe_done,
    input  logic [RESULT_LEN-1:0] pe_result,
    input  logic                  pe_zero_f,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RESULT_LEN-1:0] out_index,
    output logic                  out_last,
    output logic                  out_empty,
    output logic                  busy,
    output logic [CNT_LEN-1:0]    count,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, EMIT} state_t;

    state_t                  state_reg;
    logic [DATA_LEN-1:0]     work_reg;
    logic [DATA_LEN-1:0]     pe_data_reg;
    logic                    pe_start_reg;
    logic                    out_valid_reg;
    logic [RESULT_LEN-1:0]   out_index_reg;
    logic                    out_last_reg;
    logic                    out_empty_reg;
    logic                    busy_reg;
    logic [CNT_LEN-1:0]      count_reg;
    logic                    err_reg;

    // A result outside the vector shifts the mask to zero, so it can never count as a hit.
    logic [DATA_LEN-1:0]     hit_mask;
    logic [DATA_LEN-1:0]     work_cleared;
    logic                    idx_hit;

    assign hit_mask     = {{(DATA_LEN-1){1'b0}}, 1'b1} << pe_result;
    assign work_cleared = work_reg & ~hit_mask;
    assign idx_hit      = (int'(pe_result) < DATA_LEN) && (|(work_reg & hit_mask));

`ifdef PE_SEQ_TIMEOUT_EN
    logic [$clog2(TIMEOUT_CYCLES+1)-1:0] wd_reg;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            work_reg      <= '0;
            pe_data_reg   <= '0;
            pe_start_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_index_reg <= '0;
            out_last_reg  <= 1'b0;
            out_empty_reg <= 1'b0;
            busy_reg      <= 1'b0;
            count_reg     <= '0;
            err_reg       <= 1'b0;
`ifdef PE_SEQ_TIMEOUT_EN
            wd_reg        <= '0;
`endif
        end else begin
            pe_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        work_reg      <= in_data;
                        pe_data_reg   <= in_data;
                        count_reg     <= '0;
                        busy_reg      <= 1'b1;
                        out_last_reg  <= 1'b0;
                        out_empty_reg <= 1'b0;
                        state_reg     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (pe_ready) begin
                        pe_start_reg <= 1'b1;
                        state_reg    <= WAIT;
`ifdef PE_SEQ_TIMEOUT_EN
                        wd_reg       <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (pe_done) begin
                        out_valid_reg <= 1'b1;
                        state_reg     <= EMIT;
                        if (pe_zero_f) begin
                            out_index_reg <= '0;
                            out_empty_reg <= 1'b1;
                            out_last_reg  <= 1'b1;
                        end else if (!idx_hit) begin
                            // Encoder reported a bit that is not pending: flag it and end this vector.
                            err_reg       <= 1'b1;
                            out_index_reg <= pe_result;
                            out_empty_reg <= 1'b0;
                            out_last_reg  <= 1'b1;
                        end else begin
                            out_index_reg <= pe_result;
                            work_reg      <= work_cleared;
                            out_empty_reg <= 1'b0;
                            out_last_reg  <= (work_cleared == '0);
                        end
                    end
`ifdef PE_SEQ_TIMEOUT_EN
                    else if (int'(wd_reg) == TIMEOUT_CYCLES - 1) begin
                        err_reg       <= 1'b1;
                        out_valid_reg <= 1'b1;
                        out_index_reg <= '0;
                        out_empty_reg <= 1'b0;
                        out_last_reg  <= 1'b1;
                        state_reg     <= EMIT;
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
`endif
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (int'(count_reg) != DATA_LEN) begin
                            count_reg <= count_reg + 1'b1;
                        end
                        if (out_last_reg) begin
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            pe_data_reg <= work_reg;
                            state_reg   <= LAUNCH;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_reg == IDLE);
    assign pe_data_in = pe_data_reg;
    assign pe_start   = pe_start_reg;
    assign out_valid  = out_valid_reg;
    assign out_index  = out_index_reg;
    assign out_last   = out_last_reg;
    assign out_empty  = out_empty_reg;
    assign busy       = busy_reg;
    assign count      = count_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_pe_index_sequencer.sv
// Scoreboard bench for pe_index_sequencer with an MSB-first encoder model (latency 3, done held 2 cycles).
`timescale 1ns/1ps
module tb_pe_index_sequencer;
    localparam int DATA_LEN       = 20;
    localparam int RESULT_LEN     = $clog2(DATA_LEN);
    localparam int CNT_LEN        = $clog2(DATA_LEN + 1);
    localparam int TIMEOUT_CYCLES = 64;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_LEN-1:0]   in_data;
    logic [DATA_LEN-1:0]   pe_data_in;
    logic                  pe_start;
    logic                  pe_ready;
    logic                  pe_done;
    logic [RESULT_LEN-1:0] pe_result;
    logic                  pe_zero_f;
    logic                  out_valid;
    logic                  out_ready;
    logic [RESULT_LEN-1:0] out_index;
    logic                  out_last;
    logic                  out_empty;
    logic                  busy;
    logic [CNT_LEN-1:0]    count;
    logic                  err;

    pe_index_sequencer #(
        .DATA_LEN(DATA_LEN), .RESULT_LEN(RESULT_LEN),
        .CNT_LEN(CNT_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pe_data_in(pe_data_in), .pe_start(pe_start), .pe_ready(pe_ready), .pe_done(pe_done),
        .pe_result(pe_result), .pe_zero_f(pe_zero_f), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_last(out_last), .out_empty(out_empty), .busy(busy),
        .count(count), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Encoder model
    logic                  force_en      = 1'b0;
    logic                  suppress_done = 1'b0;
    logic [2:0]            enc_cnt_reg;
    logic [DATA_LEN-1:0]   enc_data_reg;
    logic [RESULT_LEN-1:0] enc_result;
    logic                  enc_zero;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_cnt_reg  <= '0;
            enc_data_reg <= '0;
        end else if (enc_cnt_reg == 3'd0) begin
            if (pe_start) begin
                enc_cnt_reg  <= 3'd1;
                enc_data_reg <= pe_data_in;
            end
        end else begin
            enc_cnt_reg <= (enc_cnt_reg == 3'd4) ? 3'd0 : enc_cnt_reg + 3'd1;
        end
    end

    always_comb begin
        enc_result = '0;
        enc_zero   = (enc_data_reg == '0);
        for (int i = 0; i < DATA_LEN; i++) begin
            if (enc_data_reg[i]) enc_result = RESULT_LEN'(i);
        end
    end

    assign pe_ready  = (enc_cnt_reg == 3'd0);
    assign pe_done   = (enc_cnt_reg >= 3'd3) && !suppress_done;
    assign pe_result = force_en ? RESULT_LEN'(5) : enc_result;
    assign pe_zero_f = force_en ? 1'b0 : enc_zero;

    // Scoreboard: {last, empty, index}
    logic [RESULT_LEN+1:0] exp_q[$];
    logic [RESULT_LEN+1:0] exp_beat;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    task automatic push_expected(input logic [DATA_LEN-1:0] v);
        int n = 0;
        int k = 0;
        for (int i = 0; i < DATA_LEN; i++) if (v[i]) n++;
        if (n == 0) begin
            exp_q.push_back({1'b1, 1'b1, RESULT_LEN'(0)});
        end else begin
            for (int i = DATA_LEN - 1; i >= 0; i--) begin
                if (v[i]) begin
                    k++;
                    exp_q.push_back({(k == n), 1'b0, RESULT_LEN'(i)});
                end
            end
        end
    endtask

    // Monitor state
    int   vec_beats     = 0;
    int   start_pulses  = 0;
    int   last_hs_cyc   = 0;
    logic check_spacing = 1'b0;
    logic toggle_mode   = 1'b0;
    logic prev_start    = 1'b0;
    logic prev_stall    = 1'b0;
    logic [RESULT_LEN-1:0] prev_index;
    logic prev_last;
    logic prev_empty;

    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (pe_start) start_pulses++;
                if (prev_start) check("pe_start_single_cycle", 32'(pe_start), 32'd0);
                if (prev_stall) begin
                    check("stall_valid_held", 32'(out_valid), 32'd1);
                    check("stall_index_held", 32'(out_index), 32'(prev_index));
                    check("stall_last_held", 32'(out_last), 32'(prev_last));
                    check("stall_empty_held", 32'(out_empty), 32'(prev_empty));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat_index", 32'(out_index), 32'hFFFF_FFFF);
                    end else begin
                        exp_beat = exp_q.pop_front();
                        $display("beat: index=%0d last=%0b empty=%0b count=%0d (exp index=%0d last=%0b empty=%0b)",
                                 out_index, out_last, out_empty, count,
                                 exp_beat[RESULT_LEN-1:0], exp_beat[RESULT_LEN+1], exp_beat[RESULT_LEN]);
                        check("beat_index", 32'(out_index), 32'(exp_beat[RESULT_LEN-1:0]));
                        check("beat_last", 32'(out_last), 32'(exp_beat[RESULT_LEN+1]));
                        check("beat_empty", 32'(out_empty), 32'(exp_beat[RESULT_LEN]));
                    end
                    check("count_before_beat", 32'(count), 32'(vec_beats));
                    if (check_spacing && vec_beats > 0) check("beat_spacing", 32'(cyc - last_hs_cyc), 32'd6);
                    last_hs_cyc = cyc;
                    vec_beats++;
                end
                prev_stall = out_valid && !out_ready;
                prev_index = out_index;
                prev_last  = out_last;
                prev_empty = out_empty;
                prev_start = pe_start;
            end else begin
                prev_stall = 1'b0;
                prev_start = 1'b0;
            end
        end
    end

    // out_ready: always high, or 1 cycle on / 2 off
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = toggle_mode ? (cyc % 3 == 0) : 1'b1;
        end
    end

    task automatic send(input logic [DATA_LEN-1:0] v);
        int t = 0;
        @(posedge clk); #1;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("in_ready_before_send", 32'(in_ready), 32'd1);
        vec_beats = 0;
        in_valid  = 1'b1;
        in_data   = v;
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int t = 0;
        while ((busy || out_valid || exp_q.size() != 0) && t < max_cycles) begin
            @(posedge clk); #1;
            t++;
        end
        check(tag, 32'(t < max_cycles), 32'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_pe_data_in"}, 32'(pe_data_in), 32'd0);
        check({pfx, "_pe_start"}, 32'(pe_start), 32'd0);
        check({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
        check({pfx, "_out_index"}, 32'(out_index), 32'd0);
        check({pfx, "_out_last"}, 32'(out_last), 32'd0);
        check({pfx, "_out_empty"}, 32'(out_empty), 32'd0);
        check({pfx, "_busy"}, 32'(busy), 32'd0);
        check({pfx, "_count"}, 32'(count), 32'd0);
        check({pfx, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int t;
        int entry_cyc;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;

        // Case 1: full walk, spacing L+3
        push_expected(20'h0354D);
        check_spacing = 1'b1;
        start_pulses  = 0;
        send(20'h0354D);
        wait_done("case1_done", 300);
        check_spacing = 1'b0;
        check("case1_count", 32'(count), 32'd8);
        check("case1_err", 32'(err), 32'd0);
        check("case1_pulses", 32'(start_pulses), 32'd8);

        // Case 2: all-zero vector
        push_expected(20'h0);
        send(20'h0);
        wait_done("case2_done", 100);
        check("case2_count", 32'(count), 32'd1);

        // Case 3: downstream stalls
        toggle_mode  = 1'b1;
        push_expected(20'h805C3);
        start_pulses = 0;
        send(20'h805C3);
        wait_done("case3_done", 500);
        toggle_mode  = 1'b0;
        check("case3_pulses", 32'(start_pulses), 32'd7);
        check("case3_count", 32'(count), 32'd7);

        // Case 4: reset during the third WAIT
        push_expected(20'h0354D);
        send(20'h0354D);
        n = 0;
        t = 0;
        while (n < 3 && t < 200) begin
            @(posedge clk); #1;
            if (pe_start) n++;
            t++;
        end
        check("case4_third_launch_seen", 32'(n), 32'd3);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("case4_abort");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        push_expected(20'h00001);
        send(20'h00001);
        wait_done("case4_after_reset_done", 100);
        check("case4_count", 32'(count), 32'd1);

        // Case 6: encoder never answers
        suppress_done = 1'b1;
`ifdef PE_SEQ_TIMEOUT_EN
        exp_q.push_back({1'b1, 1'b0, RESULT_LEN'(0)});
        send(20'h00010);
        t = 0;
        while (!pe_start && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        entry_cyc = cyc;
        t = 0;
        while (!err && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("case6_timeout_latency", 32'(cyc - entry_cyc), 32'(TIMEOUT_CYCLES));
        wait_done("case6_done", 50);
        check("case6_err", 32'(err), 32'd1);
`else
        entry_cyc = 0;
        send(20'h00010);
        repeat (100) @(posedge clk);
        #1;
        check("case6_busy_held", 32'(busy), 32'd1);
        check("case6_no_beat", 32'(out_valid), 32'd0);
        check("case6_err", 32'(err), 32'd0);
`endif
        suppress_done = 1'b0;
        pulse_reset();
        check("case6_err_after_reset", 32'(err), 32'd0);

        // Case 5: encoder reports a bit that is not set
        force_en = 1'b1;
        exp_q.push_back({1'b1, 1'b0, RESULT_LEN'(5)});
        send(20'h00100);
        wait_done("case5_done", 100);
        force_en = 1'b0;
        check("case5_err", 32'(err), 32'd1);
        check("case5_idle", 32'(in_ready), 32'd1);
        check("case5_busy", 32'(busy), 32'd0);
        push_expected(20'h00003);
        send(20'h00003);
        wait_done("case5_followup_done", 100);
        check("case5_err_sticky", 32'(err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
